// File: rtl/alu_control_seq.sv
// Registered ALU control decoder with an optional iterative RV32M multiply/divide sequencer.
// Define ALU_CTRL_MEXT_EN to build the M-extension decode and sequencer; otherwise the M outputs are constant.
module alu_control_seq #(
    parameter int XLEN      = 32,
    parameter int ALUOP_W   = 3,
    parameter int ALUCTRL_W = 4
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    input  logic                 en,
    input  logic                 flush,
    input  logic [ALUOP_W-1:0]   ALUOp,
    input  logic [4:0]           instruction,
    input  logic                 md_valid,
    input  logic [XLEN-1:0]      op_a,
    input  logic [XLEN-1:0]      op_b,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 md_ready,
    output logic [XLEN-1:0]      md_result,
    output logic                 md_done,
    output logic                 stall,
    output logic                 illegal
);

    localparam logic [ALUCTRL_W-1:0] C_ADD    = ALUCTRL_W'(0);
    localparam logic [ALUCTRL_W-1:0] C_SUB    = ALUCTRL_W'(1);
    localparam logic [ALUCTRL_W-1:0] C_AND    = ALUCTRL_W'(2);
    localparam logic [ALUCTRL_W-1:0] C_OR     = ALUCTRL_W'(3);
    localparam logic [ALUCTRL_W-1:0] C_XOR    = ALUCTRL_W'(4);
    localparam logic [ALUCTRL_W-1:0] C_SLL    = ALUCTRL_W'(5);
    localparam logic [ALUCTRL_W-1:0] C_SRL    = ALUCTRL_W'(6);
    localparam logic [ALUCTRL_W-1:0] C_SRA    = ALUCTRL_W'(7);
    localparam logic [ALUCTRL_W-1:0] C_SLTU   = ALUCTRL_W'(8);
    localparam logic [ALUCTRL_W-1:0] C_SLT    = ALUCTRL_W'(9);
    localparam logic [ALUCTRL_W-1:0] C_LUI    = ALUCTRL_W'(10);
    localparam logic [ALUCTRL_W-1:0] C_JAL    = ALUCTRL_W'(11);
    localparam logic [ALUCTRL_W-1:0] C_JALR   = ALUCTRL_W'(12);
`ifdef ALU_CTRL_MEXT_EN
    localparam logic [ALUCTRL_W-1:0] C_MULDIV = ALUCTRL_W'(13);
`endif

    logic                 f7_5;
    logic                 f7_0;
    logic [2:0]           f3;
    logic [ALUCTRL_W-1:0] dec_ctrl;
    logic                 dec_ill;

    assign f7_5 = instruction[4];
    assign f7_0 = instruction[3];
    assign f3   = instruction[2:0];

    always_comb begin
        dec_ctrl = C_ADD;
        dec_ill  = 1'b0;
        case (ALUOp)
            3'b000: begin
                if (f7_0) begin
`ifdef ALU_CTRL_MEXT_EN
                    if (f7_5) dec_ill = 1'b1;
                    else      dec_ctrl = C_MULDIV;
`else
                    dec_ill = 1'b1;
`endif
                end else begin
                    case (f3)
                        3'b000:  dec_ctrl = f7_5 ? C_SUB : C_ADD;
                        3'b001:  dec_ctrl = C_SLL;
                        3'b010:  dec_ctrl = C_SLT;
                        3'b011:  dec_ctrl = C_SLTU;
                        3'b100:  dec_ctrl = C_XOR;
                        3'b101:  dec_ctrl = f7_5 ? C_SRA : C_SRL;
                        3'b110:  dec_ctrl = C_OR;
                        default: dec_ctrl = C_AND;
                    endcase
                    // funct7[5] is only meaningful for SUB and SRA
                    if (f7_5 && (f3 != 3'b000) && (f3 != 3'b101)) begin
                        dec_ctrl = C_ADD;
                        dec_ill  = 1'b1;
                    end
                end
            end
            3'b011: begin
                case (f3)
                    3'b000:  dec_ctrl = C_ADD;
                    3'b001:  dec_ctrl = C_SLL;
                    3'b010:  dec_ctrl = C_SLT;
                    3'b011:  dec_ctrl = C_SLTU;
                    3'b100:  dec_ctrl = C_XOR;
                    3'b101:  dec_ctrl = f7_5 ? C_SRA : C_SRL;
                    3'b110:  dec_ctrl = C_OR;
                    default: dec_ctrl = C_AND;
                endcase
            end
            3'b001:  dec_ctrl = C_SUB;
            3'b010:  dec_ctrl = C_ADD;
            3'b100:  dec_ctrl = C_ADD;
            3'b101:  dec_ctrl = C_LUI;
            3'b110:  dec_ctrl = C_JAL;
            3'b111:  dec_ctrl = C_JALR;
            default: dec_ill  = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            ALUControl <= C_ADD;
            illegal    <= 1'b0;
        end else if (en) begin
            ALUControl <= dec_ctrl;
            illegal    <= dec_ill;
        end
    end

`ifdef ALU_CTRL_MEXT_EN
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [2*XLEN-1:0]   acc;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic                a_neg;
    logic                b_neg;
    logic [2:0]          f3_q;
    logic [CW-1:0]       count;

    logic                accept;
    logic                in_a_signed;
    logic                in_b_signed;
    logic                in_a_neg;
    logic                in_b_neg;
    logic [XLEN-1:0]     in_a_mag;
    logic [XLEN-1:0]     in_b_mag;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next;
    logic [XLEN:0]       div_shift;
    logic [XLEN+1:0]     div_trial;
    logic [2*XLEN-1:0]   div_next;

    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo;
    logic [XLEN-1:0]     rem;
    logic [XLEN-1:0]     a_orig;
    logic                div_zero;
    logic                div_ovf;
    logic [XLEN-1:0]     fix_result;

    assign accept = (state == IDLE) && md_valid && !flush;

    // MULHSU/MULHU and the unsigned divides treat one or both operands as unsigned
    assign in_a_signed = (f3 != 3'b011) && (f3 != 3'b101) && (f3 != 3'b111);
    assign in_b_signed = in_a_signed && (f3 != 3'b010);
    assign in_a_neg    = in_a_signed && op_a[XLEN-1];
    assign in_b_neg    = in_b_signed && op_b[XLEN-1];
    assign in_a_mag    = in_a_neg ? (~op_a + 1'b1) : op_a;
    assign in_b_mag    = in_b_neg ? (~op_b + 1'b1) : op_b;

    // acc = {high, multiplier} for multiply and {remainder, quotient} for divide
    assign mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, a_mag} : {(XLEN+1){1'b0}});
    assign mul_next  = {mul_sum, acc[XLEN-1:1]};
    assign div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    assign div_trial = {1'b0, div_shift} - {2'b00, b_mag};
    assign div_next  = div_trial[XLEN+1] ? {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                         : {div_trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};

    assign prod     = (a_neg ^ b_neg) ? (~acc + 1'b1) : acc;
    assign quo      = (a_neg ^ b_neg) ? (~acc[XLEN-1:0] + 1'b1) : acc[XLEN-1:0];
    assign rem      = a_neg ? (~acc[2*XLEN-1:XLEN] + 1'b1) : acc[2*XLEN-1:XLEN];
    assign a_orig   = a_neg ? (~a_mag + 1'b1) : a_mag;
    assign div_zero = (b_mag == '0);
    assign div_ovf  = a_neg && b_neg && (b_mag == XLEN'(1)) && (a_mag == {1'b1, {(XLEN-1){1'b0}}});

    always_comb begin
        fix_result = prod[XLEN-1:0];
        case (f3_q)
            3'b000:  fix_result = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:  fix_result = prod[2*XLEN-1:XLEN];
            3'b100,
            3'b101:  fix_result = div_zero ? {XLEN{1'b1}} : (div_ovf ? a_orig : quo);
            default: fix_result = div_zero ? a_orig : (div_ovf ? '0 : rem);
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = CALC;
            CALC:    if (count == CW'(XLEN-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    assign md_ready = (state == IDLE);
    assign md_done  = (state == DONE) && !flush;
    assign stall    = (state != IDLE) || accept;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            acc       <= '0;
            a_mag     <= '0;
            b_mag     <= '0;
            a_neg     <= 1'b0;
            b_neg     <= 1'b0;
            f3_q      <= 3'b000;
            count     <= '0;
            md_result <= '0;
        end else if (accept) begin
            a_mag <= in_a_mag;
            b_mag <= in_b_mag;
            a_neg <= in_a_neg;
            b_neg <= in_b_neg;
            f3_q  <= f3;
            count <= '0;
            acc   <= f3[2] ? {{XLEN{1'b0}}, in_a_mag} : {{XLEN{1'b0}}, in_b_mag};
        end else if ((state == CALC) && !flush) begin
            acc   <= f3_q[2] ? div_next : mul_next;
            count <= count + CW'(1);
        end else if ((state == FIX) && !flush) begin
            md_result <= fix_result;
        end
    end
`else
    logic unused_md_inputs;

    assign unused_md_inputs = ^{flush, md_valid, op_a, op_b};
    assign md_ready  = 1'b1;
    assign md_done   = 1'b0;
    assign stall     = 1'b0;
    assign md_result = '0;
`endif

endmodule

// File: tb/tb_alu_control_seq.sv
// Scoreboard bench for alu_control_seq: random decode traffic and M-op requests against a reference model.
// The sequencer section is compiled only when ALU_CTRL_MEXT_EN is defined, matching the design.
module tb_alu_control_seq;

    localparam int XLEN = 32;

    localparam logic [3:0] A_ADD = 4'd0, A_SUB = 4'd1, A_AND = 4'd2, A_OR = 4'd3, A_XOR = 4'd4;
    localparam logic [3:0] A_SLL = 4'd5, A_SRL = 4'd6, A_SRA = 4'd7, A_SLTU = 4'd8, A_SLT = 4'd9;
    localparam logic [3:0] A_LUI = 4'd10, A_JAL = 4'd11, A_JALR = 4'd12, A_MULDIV = 4'd13;

    logic            CLK;
    logic            RST_n;
    logic            en;
    logic            flush;
    logic [2:0]      ALUOp;
    logic [4:0]      instruction;
    logic            md_valid;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [3:0]      ALUControl;
    logic            md_ready;
    logic [XLEN-1:0] md_result;
    logic            md_done;
    logic            stall;
    logic            illegal;

    alu_control_seq #(.XLEN(XLEN), .ALUOP_W(3), .ALUCTRL_W(4)) dut (
        .CLK(CLK), .RST_n(RST_n), .en(en), .flush(flush), .ALUOp(ALUOp),
        .instruction(instruction), .md_valid(md_valid), .op_a(op_a), .op_b(op_b),
        .ALUControl(ALUControl), .md_ready(md_ready), .md_result(md_result),
        .md_done(md_done), .stall(stall), .illegal(illegal)
    );

    typedef struct packed { logic [3:0] ctrl; logic ill; } dec_t;
    typedef struct packed { logic [XLEN-1:0] res; int acc_cyc; } md_t;

    dec_t dec_q[$];
    md_t  md_q[$];
    dec_t held;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic [XLEN-1:0] last_result = '0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic dec_t decode_ref(input logic [2:0] op, input logic [4:0] ins);
        dec_t d;
        logic [3:0] base [8];
        base = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
        d.ctrl = A_ADD;
        d.ill  = 1'b0;
        case (op)
            3'd0: begin
                if (ins[3]) begin
`ifdef ALU_CTRL_MEXT_EN
                    if (ins[4]) d.ill = 1'b1;
                    else        d.ctrl = A_MULDIV;
`else
                    d.ill = 1'b1;
`endif
                end else if (!ins[4])           d.ctrl = base[ins[2:0]];
                else if (ins[2:0] == 3'd0)     d.ctrl = A_SUB;
                else if (ins[2:0] == 3'd5)     d.ctrl = A_SRA;
                else                           d.ill  = 1'b1;
            end
            3'd3:    d.ctrl = (ins[2:0] == 3'd5 && ins[4]) ? A_SRA : base[ins[2:0]];
            3'd1:    d.ctrl = A_SUB;
            3'd5:    d.ctrl = A_LUI;
            3'd6:    d.ctrl = A_JAL;
            3'd7:    d.ctrl = A_JALR;
            default: d.ctrl = A_ADD;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] md_ref(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa = $signed(a);
        longint sb = $signed(b);
        longint ua = {32'b0, a};
        longint ub = {32'b0, b};
        logic [63:0] p;
        logic ovf;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return a;
                p = sa / sb; return p[31:0];
            end
            3'd5: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'h0;
                p = sa % sb; return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Decode driver: ALUControl/illegal follow one edge later, or hold when en=0
    task automatic applyStimulus(input logic e, input logic [2:0] op, input logic [4:0] ins);
        @(negedge CLK);
        en          = e;
        ALUOp       = op;
        instruction = ins;
        if (e) held = decode_ref(op, ins);
        dec_q.push_back(held);
    endtask

    always @(posedge CLK) begin
        #1;
        if (RST_n) begin
            if (dec_q.size() > 0) begin
                dec_t d;
                d = dec_q.pop_front();
                checkOutput("alu_control", {28'b0, ALUControl}, {28'b0, d.ctrl});
                checkOutput("illegal", {31'b0, illegal}, {31'b0, d.ill});
            end
            if (md_done) begin
                if (md_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_md_done actual=1 expected=0 at cycle %0d", cyc);
                end else begin
                    md_t m;
                    m = md_q.pop_front();
                    checkOutput("md_result", md_result, m.res);
                    checkOutput("md_latency", cyc - m.acc_cyc, XLEN + 2);
                end
            end
        end
    end

`ifdef ALU_CTRL_MEXT_EN
    task automatic wait_ready();
        bit ok = 0;
        @(negedge CLK);
        for (int i = 0; i < 100; i++) begin
            if (md_ready) begin ok = 1; break; end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL md_ready_timeout actual=0 expected=1");
        end
    endtask

    task automatic md_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input bit chk);
        bit ok = 0;
        wait_ready();
        md_valid    = 1'b1;
        ALUOp       = 3'd0;
        instruction = {2'b01, f};
        op_a        = a;
        op_b        = b;
        last_result = md_ref(f, a, b);
        md_q.push_back('{res: last_result, acc_cyc: cyc});
        #1;
        if (chk) checkOutput("stall_on_accept", {31'b0, stall}, 32'd1);
        @(negedge CLK);
        md_valid = 1'b0;
        for (int i = 0; i < XLEN + 8; i++) begin
            if (md_q.size() == 0) begin ok = 1; break; end
            if (chk) begin
                checkOutput("stall_busy", {31'b0, stall}, 32'd1);
                checkOutput("ready_busy", {31'b0, md_ready}, 32'd0);
                chk = 0;
            end
            @(negedge CLK);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("[TB] FAIL md_done_timeout actual=none expected=done f3=%0d", f);
            md_q.delete();
        end
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [6];
        specials = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h2};
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
        return $urandom;
    endfunction
`endif

    initial begin
        logic [31:0] stim_a;
        RST_n = 1'b1; en = 1'b0; flush = 1'b0; ALUOp = 3'd0; instruction = 5'd0;
        md_valid = 1'b0; op_a = '0; op_b = '0;
        held = '{ctrl: A_ADD, ill: 1'b0};
        #2 RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        checkOutput("reset_alu_control", {28'b0, ALUControl}, 32'd0);
        checkOutput("reset_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("reset_md_ready", {31'b0, md_ready}, 32'd1);
        checkOutput("reset_md_done", {31'b0, md_done}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        checkOutput("reset_md_result", md_result, 32'd0);
        RST_n = 1'b1;

        applyStimulus(1'b1, 3'd0, 5'b00_000);
        applyStimulus(1'b1, 3'd0, 5'b10_000);
        applyStimulus(1'b1, 3'd0, 5'b10_101);
        applyStimulus(1'b1, 3'd0, 5'b01_000);
        applyStimulus(1'b1, 3'd3, 5'b10_101);
        applyStimulus(1'b1, 3'd3, 5'b10_001);
        applyStimulus(1'b0, 3'd5, 5'b00_000);
        applyStimulus(1'b1, 3'd0, 5'b10_110);
        for (int i = 0; i < 80; i++)
            applyStimulus($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)));
        applyStimulus(1'b1, 3'd7, 5'b00_000);
        @(negedge CLK);
        en = 1'b0;

`ifdef ALU_CTRL_MEXT_EN
        md_op(3'd0, 32'd7, 32'hFFFF_FFFD, 1'b1);
        md_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        md_op(3'd5, 32'd5, 32'd0, 1'b0);
        md_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        md_op(3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0);
        for (int i = 0; i < 24; i++)
            md_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 1'b0);

        // Flush ten cycles into CALC: no result, md_result keeps its last value
        wait_ready();
        md_valid = 1'b1; instruction = 5'b01_000; op_a = $urandom; op_b = $urandom;
        @(negedge CLK);
        md_valid = 1'b0;
        repeat (9) @(negedge CLK);
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        checkOutput("flush_md_ready", {31'b0, md_ready}, 32'd1);
        checkOutput("flush_stall", {31'b0, stall}, 32'd0);
        repeat (XLEN + 4) @(negedge CLK);
        checkOutput("flush_md_result", md_result, last_result);

        md_valid = 1'b1; flush = 1'b1;
        #1;
        checkOutput("flush_valid_stall", {31'b0, stall}, 32'd0);
        @(negedge CLK);
        md_valid = 1'b0; flush = 1'b0;
        checkOutput("flush_valid_ready", {31'b0, md_ready}, 32'd1);

        stim_a = 32'd1234;
        md_valid = 1'b1; instruction = 5'b01_100; op_a = stim_a; op_b = 32'd7;
        @(negedge CLK);
        md_valid = 1'b0;
        repeat (5) @(negedge CLK);
`else
        for (int i = 0; i < 12; i++) begin
            @(negedge CLK);
            md_valid = 1'b1; flush = 1'($urandom_range(0, 1));
            instruction = {2'b01, 3'($urandom_range(0, 7))}; op_a = $urandom; op_b = $urandom;
            #1;
            checkOutput("nomext_stall", {31'b0, stall}, 32'd0);
            checkOutput("nomext_md_ready", {31'b0, md_ready}, 32'd1);
            checkOutput("nomext_md_done", {31'b0, md_done}, 32'd0);
            checkOutput("nomext_md_result", md_result, 32'd0);
        end
        @(negedge CLK);
        md_valid = 1'b0; flush = 1'b0;
`endif
        RST_n = 1'b0;
        #1;
        held = '{ctrl: A_ADD, ill: 1'b0};
        checkOutput("midrst_alu_control", {28'b0, ALUControl}, 32'd0);
        checkOutput("midrst_illegal", {31'b0, illegal}, 32'd0);
        checkOutput("midrst_md_ready", {31'b0, md_ready}, 32'd1);
        checkOutput("midrst_md_done", {31'b0, md_done}, 32'd0);
        checkOutput("midrst_stall", {31'b0, stall}, 32'd0);
        checkOutput("midrst_md_result", md_result, 32'd0);
        @(negedge CLK);
        RST_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 5'b10_101);
        repeat (XLEN + 4) @(negedge CLK);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
